// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Optional watchdog: define UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 200000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first valid bit at or after ptr_i,
// wrapping modulo N.
module uart_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int W = $clog2(N);

  // Scan farthest-first so the nearest hit overwrites.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_i[(int'(ptr_i) + k) % N]) begin
        idx_o   = W'((int'(ptr_i) + k) % N);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to enable the WAIT_DONE watchdog.
import uart_arb_pkg::*;

module uart_tx_arb #(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data_in,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int W = $clog2(NUM_REQ);

  arb_state_e state_q, state_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0] grant_q, grant_d;
  logic [7:0]   data_q, data_d;
  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic [W-1:0] ptr_nxt;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
`endif

  uart_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign ptr_nxt = (grant_q == W'(NUM_REQ - 1))
                 ? '0 : grant_q + W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    tx_start    = 1'b0;
    req_ready   = '0;
    timeout_err = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = START;
          grant_d = pick_idx;
          data_d  = req_data[8*int'(pick_idx) +: 8];
        end
      end
      START: begin
        tx_start           = 1'b1;
        req_ready[grant_q] = 1'b1;
        state_d            = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        wd_d               = '0;
`endif
      end
      WAIT_DONE: begin
        // tx_done outranks a watchdog expiry in the same cycle
        if (tx_done) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_nxt;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
          rr_ptr_d    = ptr_nxt;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign tx_data_in = data_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);

endmodule
